// File: rtl/spim_trans_ctrl.sv
// SPI master transfer controller: sequences TX FIFO pops, byte shifting on
// SCLK/MOSI/MISO and RX FIFO pushes for one chip-select framed transfer.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for r_start with r_enable=1; cs_n high, sclk at cpol
// LOAD  | request next TX byte; stalls here while the TX FIFO is empty
// FETCH | wait one cycle for FIFO read data, then load the shift register
// SHIFT | divider-paced 16 SCLK edges, then one half-period and RX push
// DONE  | release cs_n, pulse trans_done, return to IDLE
module spim_trans_ctrl #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 r_enable,
    input  logic                 r_start,
    input  logic                 r_cpol,
    input  logic                 r_cpha,
    input  logic [DIV_WIDTH-1:0] r_clk_div,
    input  logic [3:0]           r_trans_len,
    output logic                 tx_fifo_re,
    input  logic [7:0]           tx_fifo_rdata,
    input  logic                 tx_fifo_empty,
    output logic                 rx_fifo_we,
    output logic [7:0]           rx_fifo_wdata,
    input  logic                 rx_fifo_full,
    output logic                 spi_sclk,
    output logic                 spi_cs_n,
    output logic                 spi_mosi,
    input  logic                 spi_miso,
    output logic                 busy,
    output logic                 int_status_trans_done,
    output logic                 int_status_rx_overflow
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FETCH = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state;
    logic                 cpol_q;
    logic                 cpha_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [3:0]           len_q;
    logic [4:0]           edge_cnt;
    logic [4:0]           byte_cnt;
    logic [7:0]           tx_sr;
    logic [7:0]           rx_sr;

    // Transfer sequencer with all outputs registered; edge 16 is the extra
    // half-period after the last trailing edge that closes a byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                  <= IDLE;
            cpol_q                 <= 1'b0;
            cpha_q                 <= 1'b0;
            div_q                  <= '0;
            div_cnt                <= '0;
            len_q                  <= 4'd0;
            edge_cnt               <= 5'd0;
            byte_cnt               <= 5'd0;
            tx_sr                  <= 8'h00;
            rx_sr                  <= 8'h00;
            tx_fifo_re             <= 1'b0;
            rx_fifo_we             <= 1'b0;
            rx_fifo_wdata          <= 8'h00;
            spi_sclk               <= 1'b0;
            spi_cs_n               <= 1'b1;
            spi_mosi               <= 1'b0;
            busy                   <= 1'b0;
            int_status_trans_done  <= 1'b0;
            int_status_rx_overflow <= 1'b0;
        end else begin
            tx_fifo_re             <= 1'b0;
            rx_fifo_we             <= 1'b0;
            int_status_trans_done  <= 1'b0;
            int_status_rx_overflow <= 1'b0;

            if (!r_enable && state != IDLE) begin
                // Abort: the idle level follows the live register, not the latched one.
                state    <= IDLE;
                spi_cs_n <= 1'b1;
                spi_sclk <= r_cpol;
                cpol_q   <= r_cpol;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        spi_sclk <= cpol_q;
                        if (r_start && r_enable) begin
                            cpol_q   <= r_cpol;
                            cpha_q   <= r_cpha;
                            div_q    <= r_clk_div;
                            len_q    <= r_trans_len;
                            spi_sclk <= r_cpol;
                            spi_cs_n <= 1'b0;
                            busy     <= 1'b1;
                            byte_cnt <= 5'd0;
                            state    <= LOAD;
                        end
                    end

                    LOAD: begin
                        spi_sclk <= cpol_q;
                        if (!tx_fifo_empty) begin
                            tx_fifo_re <= 1'b1;
                            state      <= FETCH;
                        end
                    end

                    FETCH: begin
                        // The cycle with tx_fifo_re high is spent waiting for read data.
                        if (!tx_fifo_re) begin
                            if (cpha_q) begin
                                tx_sr <= tx_fifo_rdata;
                            end else begin
                                spi_mosi <= tx_fifo_rdata[7];
                                tx_sr    <= {tx_fifo_rdata[6:0], 1'b0};
                            end
                            rx_sr    <= 8'h00;
                            edge_cnt <= 5'd0;
                            div_cnt  <= div_q;
                            state    <= SHIFT;
                        end
                    end

                    SHIFT: begin
                        if (div_cnt != '0) begin
                            div_cnt <= div_cnt - 1'b1;
                        end else begin
                            div_cnt <= div_q;
                            if (edge_cnt == 5'd16) begin
                                edge_cnt <= 5'd0;
                                if (rx_fifo_full) begin
                                    int_status_rx_overflow <= 1'b1;
                                end else begin
                                    rx_fifo_we    <= 1'b1;
                                    rx_fifo_wdata <= rx_sr;
                                end
                                byte_cnt <= byte_cnt + 5'd1;
                                if (byte_cnt == {1'b0, len_q}) begin
                                    state <= DONE;
                                end else begin
                                    state <= LOAD;
                                end
                            end else begin
                                spi_sclk <= ~spi_sclk;
                                edge_cnt <= edge_cnt + 5'd1;
                                // Even index is a leading edge: CPHA=1 drives, CPHA=0 samples.
                                if (edge_cnt[0] == cpha_q) begin
                                    rx_sr <= {rx_sr[6:0], spi_miso};
                                end else begin
                                    spi_mosi <= tx_sr[7];
                                    tx_sr    <= {tx_sr[6:0], 1'b0};
                                end
                            end
                        end
                    end

                    DONE: begin
                        spi_cs_n              <= 1'b1;
                        spi_sclk              <= cpol_q;
                        busy                  <= 1'b0;
                        int_status_trans_done <= 1'b1;
                        state                 <= IDLE;
                    end

                    default: begin
                        state    <= IDLE;
                        spi_cs_n <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spim_trans_ctrl.sv
// Directed bench for spim_trans_ctrl with MISO looped back to MOSI, a small
// TX FIFO model and pulse/edge monitors.
module tb_spim_trans_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       r_enable = 1'b0;
    logic       r_start = 1'b0;
    logic       r_cpol = 1'b0;
    logic       r_cpha = 1'b0;
    logic [7:0] r_clk_div = 8'd1;
    logic [3:0] r_trans_len = 4'd0;
    logic       tx_fifo_re;
    logic [7:0] tx_fifo_rdata = 8'h00;
    logic       tx_fifo_empty;
    logic       rx_fifo_we;
    logic [7:0] rx_fifo_wdata;
    logic       rx_fifo_full = 1'b0;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       busy;
    logic       int_status_trans_done;
    logic       int_status_rx_overflow;

    spim_trans_ctrl #(.DIV_WIDTH(8)) dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .r_enable               (r_enable),
        .r_start                (r_start),
        .r_cpol                 (r_cpol),
        .r_cpha                 (r_cpha),
        .r_clk_div              (r_clk_div),
        .r_trans_len            (r_trans_len),
        .tx_fifo_re             (tx_fifo_re),
        .tx_fifo_rdata          (tx_fifo_rdata),
        .tx_fifo_empty          (tx_fifo_empty),
        .rx_fifo_we             (rx_fifo_we),
        .rx_fifo_wdata          (rx_fifo_wdata),
        .rx_fifo_full           (rx_fifo_full),
        .spi_sclk               (spi_sclk),
        .spi_cs_n               (spi_cs_n),
        .spi_mosi               (spi_mosi),
        .spi_miso               (spi_miso),
        .busy                   (busy),
        .int_status_trans_done  (int_status_trans_done),
        .int_status_rx_overflow (int_status_rx_overflow)
    );

    always #5 clk = ~clk;

    assign spi_miso = spi_mosi;

    logic [7:0] tx_mem [0:31];
    logic [4:0] tx_wr = 5'd0;
    logic [4:0] tx_rd = 5'd0;
    assign tx_fifo_empty = (tx_wr == tx_rd);

    int         re_cnt = 0;
    int         re_sclk_hi = 0;
    int         rx_cnt = 0;
    int         done_cnt = 0;
    int         ovf_cnt = 0;
    int         cs_rise = 0;
    int         sclk_rise = 0;
    logic [7:0] rx_mem [0:63];
    logic [7:0] mosi_sr = 8'h00;
    time        t_last = 0;
    time        t_prev = 0;

    int checks = 0;
    int errors = 0;

    // TX FIFO read port and strobe counters, sampled at the edge the DUT drives into
    always @(posedge clk) begin
        if (tx_fifo_re) begin
            re_cnt <= re_cnt + 1;
            if (spi_sclk) re_sclk_hi <= re_sclk_hi + 1;
            if (tx_wr != tx_rd) begin
                tx_fifo_rdata <= tx_mem[tx_rd];
                tx_rd         <= tx_rd + 5'd1;
            end
        end
        if (rx_fifo_we) begin
            rx_mem[rx_cnt[5:0]] <= rx_fifo_wdata;
            rx_cnt              <= rx_cnt + 1;
        end
        if (int_status_trans_done) done_cnt <= done_cnt + 1;
        if (int_status_rx_overflow) ovf_cnt <= ovf_cnt + 1;
    end

    // MOSI as seen by a slave sampling on rising SCLK, plus SCLK period
    always @(posedge spi_sclk) begin
        sclk_rise <= sclk_rise + 1;
        mosi_sr   <= {mosi_sr[6:0], spi_mosi};
        t_prev    <= t_last;
        t_last    <= $time;
    end

    // Chip-select release counter
    always @(posedge spi_cs_n) begin
        cs_rise <= cs_rise + 1;
    end

    function automatic logic [15:0] pack_outs();
        return {spi_cs_n, spi_sclk, spi_mosi, tx_fifo_re, rx_fifo_we, rx_fifo_wdata,
                busy, int_status_trans_done, int_status_rx_overflow};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        tx_mem[tx_wr] = b;
        tx_wr = tx_wr + 5'd1;
    endtask

    task automatic pulse_start();
        @(negedge clk) r_start = 1'b1;
        @(negedge clk) r_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string tag);
        int n = 0;
        while (done_cnt == base && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done_cnt != base), 32'd1);
    endtask

    task automatic wait_rise(input int target, input logic want_low, input string tag);
        int n = 0;
        while (!(sclk_rise >= target && (!want_low || spi_sclk == 1'b0)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 3000), 32'd1);
    endtask

    int b_re, b_rx, b_done, b_ovf, b_cs, b_rise, b_hi;

    task automatic snap();
        b_re = re_cnt; b_rx = rx_cnt; b_done = done_cnt; b_ovf = ovf_cnt;
        b_cs = cs_rise; b_rise = sclk_rise; b_hi = re_sclk_hi;
    endtask

    initial begin
        // Reset
        @(negedge clk) rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(pack_outs()), 32'h8000);
        rstn = 1'b1;
        r_enable = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'({busy, spi_cs_n}), 32'b01);

        // Mode 0, div 1, one byte 0xA5; register changes and a second start mid-transfer are ignored
        r_cpol = 0; r_cpha = 0; r_clk_div = 8'd1; r_trans_len = 4'd0;
        push(8'hA5);
        snap();
        pulse_start();
        check("t1_busy_cs_low", 32'({busy, spi_cs_n}), 32'b10);
        r_clk_div = 8'd3; r_trans_len = 4'd5;
        repeat (12) @(negedge clk);
        pulse_start();
        wait_done(b_done, "t1_done_timeout");
        repeat (10) @(negedge clk);
        check("t1_rx_we_count", 32'(rx_cnt - b_rx), 32'd1);
        check("t1_rx_data", 32'(rx_mem[b_rx]), 32'hA5);
        check("t1_re_count", 32'(re_cnt - b_re), 32'd1);
        check("t1_done_count", 32'(done_cnt - b_done), 32'd1);
        check("t1_mosi_bits", 32'(mosi_sr), 32'hA5);
        check("t1_sclk_rises", 32'(sclk_rise - b_rise), 32'd8);
        check("t1_sclk_period_ns", 32'(t_last - t_prev), 32'd40);
        check("t1_idle_after", 32'({busy, spi_cs_n, spi_sclk}), 32'b010);
        r_clk_div = 8'd1; r_trans_len = 4'd0;

        // Mode 3, div 0, three bytes back to back
        r_cpol = 1; r_cpha = 1; r_clk_div = 8'd0; r_trans_len = 4'd2;
        push(8'h01); push(8'h80); push(8'hFF);
        snap();
        pulse_start();
        wait_done(b_done, "t2_done_timeout");
        @(negedge clk);
        check("t2_re_count", 32'(re_cnt - b_re), 32'd3);
        check("t2_we_count", 32'(rx_cnt - b_rx), 32'd3);
        check("t2_rx_byte0", 32'(rx_mem[b_rx]), 32'h01);
        check("t2_rx_byte1", 32'(rx_mem[b_rx + 1]), 32'h80);
        check("t2_rx_byte2", 32'(rx_mem[b_rx + 2]), 32'hFF);
        check("t2_sclk_high_at_fetch", 32'(re_sclk_hi - b_hi), 32'd3);
        check("t2_cs_single_release", 32'(cs_rise - b_cs), 32'd1);
        check("t2_sclk_rises", 32'(sclk_rise - b_rise), 32'd25);
        check("t2_sclk_period_ns", 32'(t_last - t_prev), 32'd20);
        check("t2_mosi_last_byte", 32'(mosi_sr), 32'hFF);
        check("t2_idle_sclk_high", 32'({spi_cs_n, spi_sclk}), 32'b11);

        // TX empty at start: stall in LOAD, then send 0x3C
        r_cpol = 0; r_cpha = 0; r_clk_div = 8'd1; r_trans_len = 4'd0;
        snap();
        pulse_start();
        repeat (20) @(negedge clk);
        check("t3_stall_state", 32'({busy, spi_cs_n, spi_sclk}), 32'b100);
        check("t3_stall_no_re", 32'(re_cnt - b_re), 32'd0);
        push(8'h3C);
        wait_done(b_done, "t3_done_timeout");
        check("t3_rx_data", 32'(rx_mem[b_rx]), 32'h3C);

        // RX FIFO full for a two-byte transfer
        rx_fifo_full = 1'b1;
        r_trans_len = 4'd1;
        push(8'h5A); push(8'hC3);
        snap();
        pulse_start();
        wait_done(b_done, "t4_done_timeout");
        @(negedge clk);
        check("t4_no_we", 32'(rx_cnt - b_rx), 32'd0);
        check("t4_overflow_count", 32'(ovf_cnt - b_ovf), 32'd2);
        check("t4_done_count", 32'(done_cnt - b_done), 32'd1);
        rx_fifo_full = 1'b0;

        // Enable dropped during byte 1 of 4 (mode 2), caught while SCLK is low
        r_cpol = 1; r_cpha = 0; r_clk_div = 8'd1; r_trans_len = 4'd3;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        snap();
        pulse_start();
        wait_rise(b_rise + 3, 1'b1, "t5_reach_byte1_timeout");
        r_enable = 1'b0;
        @(negedge clk);
        check("t5_abort_outputs", 32'({spi_cs_n, spi_sclk, busy}), 32'b110);
        repeat (40) @(negedge clk);
        check("t5_no_done", 32'(done_cnt - b_done), 32'd0);
        check("t5_no_we", 32'(rx_cnt - b_rx), 32'd0);
        check("t5_idle_held", 32'({spi_cs_n, busy}), 32'b10);
        r_enable = 1'b1;
        r_cpol = 0; r_trans_len = 4'd0;
        snap();
        pulse_start();
        wait_done(b_done, "t5_restart_timeout");
        check("t5_restart_rx", 32'(rx_mem[b_rx]), 32'h22);

        // Reset asserted mid-SHIFT forces reset values immediately
        r_trans_len = 4'd1;
        snap();
        pulse_start();
        wait_rise(b_rise + 2, 1'b0, "t6_reach_shift_timeout");
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("t6_async_reset_outputs", 32'(pack_outs()), 32'h8000);
        b_re = re_cnt; b_rx = rx_cnt;
        repeat (4) @(negedge clk);
        check("t6_no_strobes_in_reset", 32'((re_cnt - b_re) + (rx_cnt - b_rx)), 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_idle_after_release", 32'({busy, spi_cs_n, spi_sclk}), 32'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
